// File: rtl/demux_1to2_pkg.sv
// Shared definitions for the 2:1 operand mux and the 1:2 stream demux.
// The select polarity and the default data width are defined here so both blocks agree.
package demux_1to2_pkg;

    localparam int DEMUX_N = 32;

    localparam logic SEL_X = 1'b0;
    localparam logic SEL_Y = 1'b1;

    typedef enum logic {
        CH_X = SEL_X,
        CH_Y = SEL_Y
    } demux_chan_e;

    function automatic demux_chan_e sel_to_chan(input logic sel);
        return (sel == SEL_Y) ? CH_Y : CH_X;
    endfunction

endpackage

// File: rtl/demux_1to2_if.sv
// Stream-side bundle of demux_1to2: one select-tagged input stream and two valid/ready outputs.
// The slave modport is the demux view and the master modport is the producer/consumer view.
interface demux_1to2_if #(
    parameter int N = 32
);
    logic [N-1:0] in_data;
    logic         in_sel;
    logic         in_valid;
    logic         in_ready;

    logic [N-1:0] x_data;
    logic         x_valid;
    logic         x_ready;

    logic [N-1:0] y_data;
    logic         y_valid;
    logic         y_ready;

    modport slave (
        input  in_data, in_sel, in_valid, x_ready, y_ready,
        output in_ready, x_data, x_valid, y_data, y_valid
    );

    modport master (
        output in_data, in_sel, in_valid, x_ready, y_ready,
        input  in_ready, x_data, x_valid, y_data, y_valid
    );
endinterface

// File: rtl/demux_out_slot.sv
// One-entry output register of a demux channel: data plus valid flag with valid/ready drain.
// A load that coincides with a drain replaces the word without a bubble.
module demux_out_slot
    import demux_1to2_pkg::*;
#(
    parameter int N = DEMUX_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] load_data,
    input  logic         out_ready,
    output logic         can_load,
    output logic [N-1:0] out_data,
    output logic         out_valid
);

    logic [N-1:0] data_p0;
    logic         vld_p0;

    // Free slot or a word leaving this cycle: either way the register may be written.
    assign can_load  = !vld_p0 || out_ready;
    assign out_data  = data_p0;
    assign out_valid = vld_p0;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0  <= 1'b0;
            data_p0 <= '0;
        end else if (load) begin
            vld_p0  <= 1'b1;
            data_p0 <= load_data;
        end else if (vld_p0 && out_ready) begin
            vld_p0  <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_1to2.sv
// Registered 1-to-2 stream demultiplexer: in_sel=0 steers to channel X, in_sel=1 to channel Y.
// Define DEMUX_COUNT_EN to add the per-channel accepted-word counters x_count/y_count.
module demux_1to2
    import demux_1to2_pkg::*;
#(
    parameter int N     = DEMUX_N,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    demux_1to2_if.slave      bus
`ifdef DEMUX_COUNT_EN
    ,
    output logic [CNT_W-1:0] x_count,
    output logic [CNT_W-1:0] y_count
`endif
);

    logic x_can_load;
    logic y_can_load;
    logic sel_y;
    logic accept;
    logic x_load;
    logic y_load;

    assign sel_y = (sel_to_chan(bus.in_sel) == CH_Y);

    // in_ready depends combinationally on the selected consumer's ready; held low during reset.
    assign bus.in_ready = !rst && (sel_y ? y_can_load : x_can_load);
    assign accept       = bus.in_valid && bus.in_ready;
    assign x_load       = accept && !sel_y;
    assign y_load       = accept &&  sel_y;

    demux_out_slot #(.N(N)) u_slot_x (
        .clk       (clk),
        .rst       (rst),
        .load      (x_load),
        .load_data (bus.in_data),
        .out_ready (bus.x_ready),
        .can_load  (x_can_load),
        .out_data  (bus.x_data),
        .out_valid (bus.x_valid)
    );

    demux_out_slot #(.N(N)) u_slot_y (
        .clk       (clk),
        .rst       (rst),
        .load      (y_load),
        .load_data (bus.in_data),
        .out_ready (bus.y_ready),
        .can_load  (y_can_load),
        .out_data  (bus.y_data),
        .out_valid (bus.y_valid)
    );

`ifdef DEMUX_COUNT_EN
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return c + CNT_W'(1);
    endfunction

    // Counters wrap naturally from all-ones back to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_count <= '0;
            y_count <= '0;
        end else begin
            if (x_load) x_count <= cnt_inc(x_count);
            if (y_load) y_count <= cnt_inc(y_count);
        end
    end
`endif

endmodule

// File: tb/tb_demux_1to2.sv
// Directed self-checking bench for demux_1to2 (counter checks only when DEMUX_COUNT_EN is defined).
// Inputs change 1 time unit after the rising edge; outputs are checked there as well.
module tb_demux_1to2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    demux_1to2_if #(.N(32)) bus ();

`ifdef DEMUX_COUNT_EN
    logic [3:0] x_count;
    logic [3:0] y_count;
    demux_1to2 #(.N(32), .CNT_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .x_count (x_count),
        .y_count (y_count)
    );
`else
    demux_1to2 #(.N(32), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
`endif

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [31:0] d);
        bus.in_valid = v;
        bus.in_sel   = s;
        bus.in_data  = d;
    endtask

    task automatic chk_cnt(input string tag, input logic [3:0] ex, input logic [3:0] ey);
`ifdef DEMUX_COUNT_EN
        chk({tag, "_xcnt"}, 32'(x_count), 32'(ex));
        chk({tag, "_ycnt"}, 32'(y_count), 32'(ey));
`else
        if (ex != ey) begin end
`endif
    endtask

    // Upstream must hold a refused word stable until it is accepted.
    logic        pend      = 1'b0;
    logic [31:0] pend_data = '0;
    logic        pend_sel  = 1'b0;
    always @(posedge clk) begin
        if (pend && bus.in_valid) begin
            chk("hold_data", bus.in_data, pend_data);
            chk("hold_sel", 32'(bus.in_sel), 32'(pend_sel));
        end
        pend      <= bus.in_valid && !bus.in_ready && !rst;
        pend_data <= bus.in_data;
        pend_sel  <= bus.in_sel;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        drive(1'b0, 1'b0, 32'h0);
        bus.x_ready = 1'b0;
        bus.y_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();

        // Reset state
        drive(1'b1, 1'b0, 32'h0000_0009);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_x_valid", 32'(bus.x_valid), 32'd0);
        chk("rst_y_valid", 32'(bus.y_valid), 32'd0);
        chk("rst_x_data", bus.x_data, 32'h0);
        chk("rst_y_data", bus.y_data, 32'h0);
        chk_cnt("rst", 4'd0, 4'd0);
        tick();

        // Single word to X
        rst = 1'b0;
        bus.x_ready = 1'b1;
        drive(1'b1, 1'b0, 32'h0000_0001);
        #1;
        chk("t1_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        drive(1'b0, 1'b0, 32'h0);
        chk("t1_x_valid", 32'(bus.x_valid), 32'd1);
        chk("t1_x_data", bus.x_data, 32'h0000_0001);
        chk("t1_y_valid", 32'(bus.y_valid), 32'd0);
        chk_cnt("t1", 4'd1, 4'd0);
        tick();
        chk("t1_x_drained", 32'(bus.x_valid), 32'd0);
        chk("t1_x_data_held", bus.x_data, 32'h0000_0001);

        // Back-to-back stream to Y
        bus.y_ready = 1'b1;
        drive(1'b1, 1'b1, 32'h8000_0000);
        #1;
        chk("t2_rdy0", 32'(bus.in_ready), 32'd1);
        tick();
        chk("t2_y0", bus.y_data, 32'h8000_0000);
        chk("t2_v0", 32'(bus.y_valid), 32'd1);
        drive(1'b1, 1'b1, 32'h4000_0000);
        #1;
        chk("t2_rdy1", 32'(bus.in_ready), 32'd1);
        tick();
        chk("t2_y1", bus.y_data, 32'h4000_0000);
        chk("t2_v1", 32'(bus.y_valid), 32'd1);
        drive(1'b1, 1'b1, 32'h0000_0003);
        #1;
        chk("t2_rdy2", 32'(bus.in_ready), 32'd1);
        tick();
        chk("t2_y2", bus.y_data, 32'h0000_0003);
        chk("t2_v2", 32'(bus.y_valid), 32'd1);
        chk("t2_x_valid", 32'(bus.x_valid), 32'd0);
        chk_cnt("t2", 4'd1, 4'd3);
        drive(1'b0, 1'b0, 32'h0);
        tick();
        chk("t2_y_drained", 32'(bus.y_valid), 32'd0);

        // Stall X
        bus.x_ready = 1'b0;
        drive(1'b1, 1'b0, 32'hA5A5_0001);
        tick();
        chk("t3_x_full", 32'(bus.x_valid), 32'd1);
        chk("t3_x_data", bus.x_data, 32'hA5A5_0001);
        drive(1'b1, 1'b0, 32'h0000_0055);
        #1;
        chk("t3_stall_rdy", 32'(bus.in_ready), 32'd0);
        tick();
        chk("t3_x_held", bus.x_data, 32'hA5A5_0001);
        chk("t3_x_still", 32'(bus.x_valid), 32'd1);
        chk_cnt("t3a", 4'd2, 4'd0 + 4'd3);
        drive(1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b1, 1'b1, 32'h0000_0077);
        #1;
        chk("t3_y_rdy", 32'(bus.in_ready), 32'd1);
        tick();
        chk("t3_y_acc", bus.y_data, 32'h0000_0077);
        chk("t3_y_valid", 32'(bus.y_valid), 32'd1);
        chk("t3_x_kept", bus.x_data, 32'hA5A5_0001);
        drive(1'b1, 1'b0, 32'h0000_0055);
        #1;
        chk("t3_rdy_blocked", 32'(bus.in_ready), 32'd0);
        tick();
        bus.x_ready = 1'b1;
        #1;
        chk("t3_rdy_release", 32'(bus.in_ready), 32'd1);
        tick();
        chk("t3_x_new", bus.x_data, 32'h0000_0055);
        chk("t3_x_valid", 32'(bus.x_valid), 32'd1);
        chk_cnt("t3", 4'd3, 4'd4);

        // Same-cycle drain and refill on X
        drive(1'b1, 1'b0, 32'hDEAD_BEEF);
        #1;
        chk("t4_rdy", 32'(bus.in_ready), 32'd1);
        tick();
        chk("t4_x_valid", 32'(bus.x_valid), 32'd1);
        chk("t4_x_data", bus.x_data, 32'hDEAD_BEEF);
        drive(1'b1, 1'b0, 32'h1234_5678);
        #1;
        chk("t4_rdy2", 32'(bus.in_ready), 32'd1);
        tick();
        chk("t4_x_valid2", 32'(bus.x_valid), 32'd1);
        chk("t4_x_data2", bus.x_data, 32'h1234_5678);
        chk_cnt("t4", 4'd5, 4'd4);

        // Reset with both slots full
        bus.x_ready = 1'b0;
        bus.y_ready = 1'b0;
        drive(1'b1, 1'b1, 32'h0000_0022);
        tick();
        chk("t5_x_full", 32'(bus.x_valid), 32'd1);
        chk("t5_y_full", 32'(bus.y_valid), 32'd1);
        chk("t5_y_data", bus.y_data, 32'h0000_0022);
        chk_cnt("t5a", 4'd5, 4'd5);
        rst = 1'b1;
        drive(1'b1, 1'b0, 32'h0000_0033);
        #1;
        chk("t5_rst_rdy", 32'(bus.in_ready), 32'd0);
        tick();
        chk("t5_x_clr", 32'(bus.x_valid), 32'd0);
        chk("t5_y_clr", 32'(bus.y_valid), 32'd0);
        chk("t5_x_data_clr", bus.x_data, 32'h0);
        chk("t5_rst_rdy2", 32'(bus.in_ready), 32'd0);
        chk_cnt("t5", 4'd0, 4'd0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0);
        tick();

        // 17 words to X: 4-bit counter wraps through zero to 1
        bus.x_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 1'b0, 32'(i) + 32'h100);
            #1;
            chk("t6_rdy", 32'(bus.in_ready), 32'd1);
            tick();
            if (i == 15) chk_cnt("t6_wrap", 4'd0, 4'd0);
        end
        drive(1'b0, 1'b0, 32'h0);
        chk("t6_x_last", bus.x_data, 32'h0000_0110);
        chk("t6_x_valid", 32'(bus.x_valid), 32'd1);
        chk_cnt("t6", 4'd1, 4'd0);
        tick();
        chk("t6_x_drained", 32'(bus.x_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/demux_1to2.md
# demux_1to2

Registered 1-to-2 stream demultiplexer: the routing counterpart of the 2:1 operand mux. Takes one N-bit word stream with a per-word select bit and steers each word into one of two output channels, X (select 0) or Y (select 1), each behind a one-entry output register with valid/ready handshaking. It sits between a shared result bus and two independent consumers, for example ALU result write-back versus a debug/trace sink.

## Interface
- N, 32, data width in bits for input and both outputs
- CNT_W, 16, width of the per-channel transfer counters (only present with DEMUX_COUNT_EN)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_data  in  N  input word
- in_sel  in  1  destination: 0 → X, 1 → Y
- in_valid  in  1  in_data/in_sel valid this cycle
- in_ready  out  1  block accepts the word this cycle
- x_data, y_data  out  N  channel output words (registered)
- x_valid, y_valid  out  1  channel holds a word
- x_ready, y_ready  in  1  consumer takes the word this cycle
- x_count, y_count  out  CNT_W  accepted-word counters (only with DEMUX_COUNT_EN)

## Operation
- Each channel has one slot: data register plus valid flag.
- Slot c can load when !c_valid || c_ready.
- in_ready = (in_sel ? can_load_Y : can_load_X). This is combinational from in_sel and the selected channel's ready.
- Input transfer happens when in_valid && in_ready. On that edge the selected slot loads in_data and sets valid. The other slot is untouched.
- Output transfer happens when c_valid && c_ready. If no load occurs on the same edge, c_valid clears. c_data holds its last value; it is not zeroed.
- Simultaneous drain and load on the same channel: the new word replaces the old one and c_valid stays 1, so throughput is one word per cycle per channel.
- Channels are independent. A stalled channel (c_valid=1, c_ready=0) blocks only words selected to it. in_ready drops only while in_sel points at the stalled channel.
- Upstream rule: while in_valid=1 and the word is not accepted, in_data and in_sel must stay stable. The bench flags any violation.
- Words are never dropped or duplicated, and per-channel order is preserved.

## Timing
- Reset values: x_valid=y_valid=0, x_data=y_data=0, counters=0. in_ready then follows the empty slots, so it is 1 in the first cycle after reset if in_valid is asserted.
- Latency is 1 cycle: a word accepted at edge k is visible on c_data/c_valid after edge k.
- rst asserted mid-operation clears both valids at the next edge. Buffered words are discarded and their consumers see no transfer. While rst=1, nothing is accepted and in_ready is forced to 0.
- The clk→in_ready path goes through c_valid. The c_ready→in_ready path is combinational, and integrators must not loop it back.

## Configuration
- DEMUX_COUNT_EN defined: x_count/y_count ports exist. Each counter increments on every input transfer to its channel and wraps modulo 2^CNT_W, going from all-ones to 0. Counters reset to 0 on rst.
- DEMUX_COUNT_EN undefined: the counter ports and logic are absent. All other behaviour is identical.

## Structure
- Shared package: SEL_X=1'b0 and SEL_Y=1'b1 constants, plus the default N=32, so the mux and demux agree on select polarity.
- Sub-module demux_out_slot (parameter N) holds one channel's data/valid register and exposes can_load. It is instantiated twice. The top level holds only the select decode, the in_ready mux and the optional counters.

## Test plan
- Reset, then send in_data=32'h0000_0001 with in_sel=0 and x_ready=1. Required: x_valid=1 and x_data=1 one cycle later, y_valid stays 0, x_count=1.
- Back-to-back stream of 32'h8000_0000, 32'h4000_0000, 32'h0000_0003 to Y with y_ready held at 1. Required: one word per cycle in order, in_ready constant 1, y_count=3.
- Stall X: x_ready=0 with X full, then send to X. Required: in_ready=0 and x_data held. Send to Y in the next cycle: in_ready=1 and Y accepts. Release x_ready: the pending X word is accepted one cycle later.
- Same-cycle drain and refill on X: x_valid=1, x_ready=1, new word 32'hDEAD_BEEF arriving. Required: x_valid stays 1, x_data=32'hDEAD_BEEF, and there is no bubble.
- Assert rst with both slots full. Required: next cycle x_valid=y_valid=0, counters 0, in_ready=0 while rst=1.
- With DEMUX_COUNT_EN and CNT_W=4, send 17 words to X. Required: x_count=1 after wrap, y_count=0.
